// File: rtl/mem_tap_pkg.sv
// mem_tap_pkg
// Shared constants and the record type for the result-tap streamer.
//   IDX_W     width of a tap index in a record
//   NTAP_MAX  largest tap count an IDX_W index can address
//   TAP_DW    tap value width carried in a record
//   TAP_TS_W  timestamp width carried in a record
//   COAL_MAX  saturation value of the coalesce counter
//   tap_rec_t {idx, data[, ts]} record as stored in the FIFO
// Optional feature macro: MEM_TAP_TS_EN adds the ts field to tap_rec_t.
package mem_tap_pkg;

    localparam int          IDX_W    = 4;
    localparam int          NTAP_MAX = 16;
    localparam int          TAP_DW   = 8;
    localparam int          TAP_TS_W = 16;
    localparam logic [7:0]  COAL_MAX = 8'hFF;

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [TAP_DW-1:0]   data;
`ifdef MEM_TAP_TS_EN
        logic [TAP_TS_W-1:0] ts;
`endif
    } tap_rec_t;

endpackage

// File: rtl/mem_tap_streamer_fifo.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. dout shows the head entry
// whenever empty=0; a pop consumes it at the rising edge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push, din    write request and data; accepted when not full or when a
//                pop happens on the same edge
//   full         DEPTH entries held
//   pop          consume head; ignored while empty
//   dout         head entry
//   empty        no entries held
//   count        number of entries held
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_tap_streamer.sv
// mem_tap_streamer
// Watches NTAP packed result taps, detects per-tap value changes against a
// one-cycle snapshot and streams each change as an {idx,value[,ts]} record
// through a FWFT FIFO onto a valid/ready port. A change on a tap that still
// has an unsent record is merged into it (the latest value is sent) and
// counted in coal_cnt. The taps are never back-pressured.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tap_flat   taps packed, tap i at [i*DW +: DW]
//   out_valid  record available
//   out_ready  sink accepts; transfer on out_valid && out_ready
//   out_idx    tap index of head record (0 when empty)
//   out_data   tap value of head record (0 when empty)
//   out_ts     capture timestamp of head record (0 when empty or without MEM_TAP_TS_EN)
//   coal_cnt   saturating count of merged changes
// Optional feature macro: MEM_TAP_TS_EN adds a free-running timestamp
// latched into every record at push time.
module mem_tap_streamer
    import mem_tap_pkg::*;
#(
    parameter int NTAP       = 11,
    parameter int DW         = TAP_DW,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = TAP_TS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NTAP*DW-1:0]   tap_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic [DW-1:0]        out_data,
    output logic [TS_W-1:0]      out_ts,
    output logic [7:0]           coal_cnt
);

    localparam int REC_W = $bits(tap_rec_t);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NTAP*DW-1:0] snap_q;
    logic [NTAP-1:0]    pending;
    logic [NTAP-1:0]    changed;
    logic [NTAP-1:0]    pick_onehot;
    logic [NTAP-1:0]    clr;
    logic [NTAP-1:0]    coal_hits;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [DW-1:0]      pick_data;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   unused_fifo_count;
    tap_rec_t           push_rec;
    tap_rec_t           head_rec;

    function automatic logic [IDX_W:0] popcount(input logic [NTAP-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (v[i]) begin
                n = n + 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [IDX_W:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {{(8-IDX_W){1'b0}}, b};
        return s[8] ? COAL_MAX : s[7:0];
    endfunction

    always_comb begin
        changed = '0;
        for (int i = 0; i < NTAP; i++) begin
            changed[i] = (tap_flat[i*DW +: DW] != snap_q[i*DW +: DW]);
        end
    end

    // Lowest-index pending tap wins; its value comes from the snapshot so the
    // record always carries the most recently captured value.
    always_comb begin
        pick_vld    = 1'b0;
        pick_idx    = '0;
        pick_data   = '0;
        pick_onehot = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (!pick_vld && pending[i]) begin
                pick_vld       = 1'b1;
                pick_idx       = IDX_W'(i);
                pick_data      = snap_q[i*DW +: DW];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    assign pop  = out_valid && out_ready;
    assign push = pick_vld && (!fifo_full || pop);
    assign clr  = push ? pick_onehot : '0;
    // A change on the tap being pushed this edge starts a fresh record, so it
    // is not a merge.
    assign coal_hits = changed & pending & ~clr;

`ifdef MEM_TAP_TS_EN
    logic [TS_W-1:0] ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end
`endif

    always_comb begin
        push_rec      = '0;
        push_rec.idx  = pick_idx;
        push_rec.data = pick_data;
`ifdef MEM_TAP_TS_EN
        push_rec.ts   = ts;
`endif
    end

    // Capture stage: snapshot, pending mask (set beats clear), merge counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= '0;
            pending  <= '0;
            coal_cnt <= '0;
        end else begin
            snap_q   <= tap_flat;
            pending  <= (pending & ~clr) | changed;
            coal_cnt <= sat_add(coal_cnt, popcount(coal_hits));
        end
    end

    // Record queue.
    sync_fifo_fwft #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_rec),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head_rec),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_idx   = fifo_empty ? '0 : head_rec.idx;
    assign out_data  = fifo_empty ? '0 : head_rec.data;
`ifdef MEM_TAP_TS_EN
    assign out_ts    = fifo_empty ? '0 : head_rec.ts;
`else
    assign out_ts    = '0;
`endif

endmodule

// File: tb/tb_mem_tap_streamer.sv
module tb_mem_tap_streamer;

    localparam int NTAP = 11;
    localparam int DW   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NTAP*DW-1:0]   tap_flat = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [3:0]           out_idx;
    logic [DW-1:0]        out_data;
    logic [15:0]          out_ts;
    logic [7:0]           coal_cnt;

    int tests = 0;
    int fails = 0;
    logic [3:0]    exp_idx[$];
    logic [DW-1:0] exp_data[$];

    always #5 clk = ~clk;

    mem_tap_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_flat  (tap_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .coal_cnt  (coal_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tap(input int i, input logic [DW-1:0] v);
        tap_flat[i*DW +: DW] = v;
    endtask

    task automatic expect_rec(input int i, input logic [DW-1:0] v);
        exp_idx.push_back(4'(i));
        exp_data.push_back(v);
    endtask

    // Requires out_ready=1: every cycle with out_valid is a transfer.
    task automatic drain_check(input string tag);
        int budget;
        budget = 0;
        while (exp_idx.size() != 0 && budget < 80) begin
            if (out_valid) begin
                chk({tag, " idx"}, 32'(out_idx), 32'(exp_idx.pop_front()));
                chk({tag, " data"}, 32'(out_data), 32'(exp_data.pop_front()));
            end
            tick();
            budget++;
        end
        chk({tag, " records left"}, exp_idx.size(), 0);
        exp_idx.delete();
        exp_data.delete();
    endtask

    initial begin
        logic seen;

        // Reset state
        tick();
        tick();
        chk("rst valid", 32'(out_valid), 0);
        chk("rst idx", 32'(out_idx), 0);
        chk("rst data", 32'(out_data), 0);
        chk("rst ts", 32'(out_ts), 0);
        chk("rst coal", 32'(coal_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Quiet taps produce nothing
        seen = 1'b0;
        repeat (100) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("idle no record", 32'(seen), 0);
        chk("idle coal", 32'(coal_cnt), 0);

        // Single change: mem23 -> 27, visible two edges later, once
        set_tap(3, 8'd27);
        tick();
        chk("single early valid", 32'(out_valid), 0);
        tick();
        chk("single valid", 32'(out_valid), 1);
        chk("single idx", 32'(out_idx), 3);
        chk("single data", 32'(out_data), 27);
        chk("single ts", 32'(out_ts), 0);
        tick();
        chk("single once", 32'(out_valid), 0);

        // Three taps change together -> consecutive records in index order
        set_tap(9, 8'h99);
        set_tap(2, 8'h11);
        set_tap(5, 8'h55);
        tick();
        chk("multi early valid", 32'(out_valid), 0);
        tick();
        chk("multi r0 valid", 32'(out_valid), 1);
        chk("multi r0 idx", 32'(out_idx), 2);
        chk("multi r0 data", 32'(out_data), 8'h11);
        tick();
        chk("multi r1 idx", 32'(out_idx), 5);
        chk("multi r1 data", 32'(out_data), 8'h55);
        tick();
        chk("multi r2 idx", 32'(out_idx), 9);
        chk("multi r2 data", 32'(out_data), 8'h99);
        tick();
        chk("multi end", 32'(out_valid), 0);

        // Back-pressure and merging: fill FIFO, then change everything again
        out_ready = 1'b0;
        for (int i = 0; i < NTAP; i++) set_tap(i, 8'(8'h40 + i));
        repeat (12) tick();
        chk("bp valid", 32'(out_valid), 1);
        chk("bp head idx", 32'(out_idx), 0);
        chk("bp head data", 32'(out_data), 8'h40);
        chk("bp coal before", 32'(coal_cnt), 0);
        for (int i = 0; i < NTAP; i++) set_tap(i, 8'(8'h80 + i));
        repeat (4) tick();
        chk("bp coal", 32'(coal_cnt), 3);
        chk("bp head stable idx", 32'(out_idx), 0);
        chk("bp head stable data", 32'(out_data), 8'h40);
        for (int i = 0; i < 8; i++) expect_rec(i, 8'(8'h40 + i));
        for (int i = 0; i < NTAP; i++) expect_rec(i, 8'(8'h80 + i));
        out_ready = 1'b1;
        drain_check("bp drain");
        chk("bp drained", 32'(out_valid), 0);
        chk("bp coal after", 32'(coal_cnt), 3);

        // Reset with records queued discards them; taps are re-dumped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) set_tap(i, 8'(8'hA0 + i));
        repeat (8) tick();
        chk("rq valid", 32'(out_valid), 1);
        chk("rq head idx", 32'(out_idx), 0);
        chk("rq head data", 32'(out_data), 8'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rq rst valid", 32'(out_valid), 0);
        chk("rq rst idx", 32'(out_idx), 0);
        chk("rq rst data", 32'(out_data), 0);
        chk("rq rst coal", 32'(coal_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_rec(i, 8'(8'hA0 + i));
        for (int i = 5; i < NTAP; i++) expect_rec(i, 8'(8'h80 + i));
        tick();
        drain_check("redump");
        chk("redump end", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
